// File: rtl/output_serializer.sv
// Output port of the Basic Computer: latches a word into OUTR, drops FGO and
// sends it as an async serial frame (start, data LSB first, stop).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, FGO=1, waiting for an OUT strobe
// S_START | start bit (low) on the line
// S_DATA  | data bit bit_q of OUTR on the line
// S_STOP  | stop bit (high) on the line; FGO rises on its last edge
module output_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int CLOCKS_PER_BIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  fgo_out,
  output logic                  serial_out,
  output logic                  busy_out,
  output logic [DATA_WIDTH-1:0] outr_out
);

  localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] outr_q, outr_d;
  logic                  fgo_q, fgo_d;
  logic                  serial_q, serial_d;

  logic          cyc_end;
  logic          bit_end;
  logic          accept;
  logic [BW-1:0] bit_nxt;

  assign cyc_end = (cyc_q == CYC_LAST);
  assign bit_end = (bit_q == BIT_LAST);
  assign accept  = load_in && fgo_q && (state_q == S_IDLE);
  assign bit_nxt = bit_q + BW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      outr_q   <= '0;
      fgo_q    <= 1'b1;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      outr_q   <= outr_d;
      fgo_q    <= fgo_d;
      serial_q <= serial_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: if (cyc_end) state_d = S_DATA;
      S_DATA:  if (cyc_end && bit_end) state_d = S_STOP;
      S_STOP:  if (cyc_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Line and FGO are computed one edge ahead so every output comes from a flop.
  always_comb begin
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    outr_d   = outr_q;
    fgo_d    = fgo_q;
    serial_d = serial_q;
    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        if (accept) begin
          outr_d   = data_in;
          fgo_d    = 1'b0;
          serial_d = 1'b0;
          cyc_d    = '0;
        end
      end
      S_START: begin
        if (cyc_end) begin
          cyc_d    = '0;
          bit_d    = '0;
          serial_d = outr_q[0];
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cyc_end) begin
          cyc_d = '0;
          if (bit_end) begin
            serial_d = 1'b1;
          end else begin
            bit_d    = bit_nxt;
            serial_d = outr_q[bit_nxt];
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_STOP: begin
        serial_d = 1'b1;
        if (cyc_end) begin
          cyc_d = '0;
          fgo_d = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        cyc_d    = '0;
        bit_d    = '0;
        fgo_d    = 1'b1;
        serial_d = 1'b1;
      end
    endcase
  end

  assign fgo_out    = fgo_q;
  assign busy_out   = ~fgo_q;
  assign serial_out = serial_q;
  assign outr_out   = outr_q;

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer: default 8-bit/4-clock instance plus a
// 4-bit/1-clock instance, line sampled on the falling edge.
module tb_output_serializer;

  logic       clk_sys;
  logic       rst;
  logic       load_a, load_b;
  logic [7:0] data_a, outr_a;
  logic [3:0] data_b, outr_b;
  logic       fgo_a, serial_a, busy_a;
  logic       fgo_b, serial_b, busy_b;

  int checks   = 0;
  int failures = 0;

  output_serializer #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(4)) u_dut_a (
    .clock      (clk_sys),
    .reset      (rst),
    .load_in    (load_a),
    .data_in    (data_a),
    .fgo_out    (fgo_a),
    .serial_out (serial_a),
    .busy_out   (busy_a),
    .outr_out   (outr_a)
  );

  output_serializer #(.DATA_WIDTH(4), .CLOCKS_PER_BIT(1)) u_dut_b (
    .clock      (clk_sys),
    .reset      (rst),
    .load_in    (load_b),
    .data_in    (data_b),
    .fgo_out    (fgo_b),
    .serial_out (serial_b),
    .busy_out   (busy_b),
    .outr_out   (outr_b)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level k cycles after the accepting edge, 8 bits x 4 clocks.
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k < 4) return 1'b0;
    else if (k < 36) return d[(k - 4) / 4];
    else return 1'b1;
  endfunction

  // Entered at the falling edge before the accepting edge, load already driven.
  task automatic run_frame(input logic [7:0] d, input int inj_k, input logic [7:0] inj_d,
                           input logic hold, input logic [7:0] next_d);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_sys);
      check_val($sformatf("a_line_k%0d", k), {31'd0, serial_a}, {31'd0, exp_bit(d, k)});
      check_val($sformatf("a_fgo_k%0d", k), {31'd0, fgo_a}, 32'd0);
      check_val($sformatf("a_busy_k%0d", k), {31'd0, busy_a}, 32'd1);
      check_val($sformatf("a_outr_k%0d", k), {24'd0, outr_a}, {24'd0, d});
      if (hold) begin
        load_a = 1'b1;
        data_a = (k == 39) ? next_d : d;
      end else if (k == inj_k) begin
        load_a = 1'b1;
        data_a = inj_d;
      end else begin
        load_a = 1'b0;
      end
    end
    @(negedge clk_sys);
    check_val("a_fgo_end", {31'd0, fgo_a}, 32'd1);
    check_val("a_line_end", {31'd0, serial_a}, 32'd1);
    check_val("a_busy_end", {31'd0, busy_a}, 32'd0);
    check_val("a_outr_end", {24'd0, outr_a}, {24'd0, d});
    if (!hold) load_a = 1'b0;
  endtask

  initial begin
    logic [5:0] seq_b;
    rst    = 1'b1;
    load_a = 1'b0;
    data_a = 8'h00;
    load_b = 1'b0;
    data_b = 4'h0;
    #12;
    check_val("rst_fgo", {31'd0, fgo_a}, 32'd1);
    check_val("rst_line", {31'd0, serial_a}, 32'd1);
    check_val("rst_busy", {31'd0, busy_a}, 32'd0);
    check_val("rst_outr", {24'd0, outr_a}, 32'd0);
    check_val("rst_b_fgo", {31'd0, fgo_b}, 32'd1);
    check_val("rst_b_line", {31'd0, serial_b}, 32'd1);
    @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);

    // Plain A5 frame
    load_a = 1'b1; data_a = 8'hA5;
    run_frame(8'hA5, -1, 8'h00, 1'b0, 8'h00);

    // A5 frame with a 3C load attempted while busy
    @(negedge clk_sys);
    load_a = 1'b1; data_a = 8'hA5;
    run_frame(8'hA5, 9, 8'h3C, 1'b0, 8'h00);

    // load held high: 01 then FF back to back, one FGO-high cycle between
    @(negedge clk_sys);
    load_a = 1'b1; data_a = 8'h01;
    run_frame(8'h01, -1, 8'h00, 1'b1, 8'hFF);
    run_frame(8'hFF, -1, 8'h00, 1'b0, 8'h00);

    // Constant-low data field
    @(negedge clk_sys);
    load_a = 1'b1; data_a = 8'h00;
    run_frame(8'h00, -1, 8'h00, 1'b0, 8'h00);

    // Reset in the middle of a frame
    @(negedge clk_sys);
    load_a = 1'b1; data_a = 8'h5A;
    @(negedge clk_sys);
    load_a = 1'b0;
    check_val("mid_pre_fgo", {31'd0, fgo_a}, 32'd0);
    repeat (14) @(negedge clk_sys);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_fgo", {31'd0, fgo_a}, 32'd1);
    check_val("mid_rst_line", {31'd0, serial_a}, 32'd1);
    check_val("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    check_val("mid_rst_outr", {24'd0, outr_a}, 32'd0);
    @(negedge clk_sys);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_sys);
      check_val($sformatf("post_rst_line_k%0d", k), {31'd0, serial_a}, 32'd1);
      check_val($sformatf("post_rst_fgo_k%0d", k), {31'd0, fgo_a}, 32'd1);
    end

    // Narrow instance: 4 bits, one clock per bit, data 0110
    seq_b = 6'b101100;
    load_b = 1'b1; data_b = 4'b0110;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_sys);
      load_b = 1'b0;
      check_val($sformatf("b_line_k%0d", k), {31'd0, serial_b}, {31'd0, seq_b[k]});
      check_val($sformatf("b_fgo_k%0d", k), {31'd0, fgo_b}, 32'd0);
      check_val($sformatf("b_busy_k%0d", k), {31'd0, busy_b}, 32'd1);
    end
    @(negedge clk_sys);
    check_val("b_fgo_end", {31'd0, fgo_b}, 32'd1);
    check_val("b_line_end", {31'd0, serial_b}, 32'd1);
    check_val("b_outr_end", {28'd0, outr_b}, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
